// File: rtl/ca_ctrl_pkg.sv
// Shared definitions for the cell_logic chain controller: state encoding and width helpers.
// Purely declarative: no latency and no flow control of its own.
package ca_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_LOAD       = 3'd0,
    ST_INIT       = 3'd1,
    ST_CONFIGURED = 3'd2,
    ST_RUN_STEP   = 3'd3,
    ST_RUN_WAIT   = 3'd4
  } state_t;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int beats_of(input int tw, input int word_w);
    return tw / word_w;
  endfunction

  function automatic bit tw_fits_words(input int tw, input int word_w);
    return (tw % word_w) == 0;
  endfunction

endpackage

// File: rtl/ca_table_assembler.sv
// Packs WORD_W-bit config beats into a TW-bit rule table, beat 0 in the LSBs.
// Latency: a beat lands in chain_table the cycle after it is accepted; backpressure is owned by the caller.
module ca_table_assembler
  import ca_ctrl_pkg::*;
#(
  parameter int TW     = 512,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [WORD_W-1:0] data,
  output logic [TW-1:0]     chain_table,
  output logic              last_beat
);

  localparam int BEATS = beats_of(TW, WORD_W);
  localparam int BW    = clog2_min1(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [BW-1:0] beat;

  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat        <= '0;
      chain_table <= '0;
    end else if (accept) begin
      chain_table[int'(beat)*WORD_W +: WORD_W] <= data;
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

endmodule

// File: rtl/ca_rule_loader.sv
// Loads NUM_CELLS rule tables down the cell_logic init chain, then sequences generation runs.
// Latency: chain_init the cycle after a table's last beat; cfg_ready is low outside LOAD, step_en waits on step_done.
module ca_rule_loader
  import ca_ctrl_pkg::*;
#(
  parameter  int NUM_INPUTS = 9,
  parameter  int NUM_CELLS  = 16,
  parameter  int WORD_W     = 32,
  parameter  int GEN_W      = 16,
  localparam int TW         = 2 ** NUM_INPUTS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              chain_init,
  output logic [TW-1:0]     chain_table,
  output logic              configured,
  input  logic              reconfig,
  input  logic              start,
  input  logic [GEN_W-1:0]  num_gens,
  output logic              step_en,
  input  logic              step_done,
  output logic              busy,
  output logic [GEN_W-1:0]  gen_count,
  output logic              done
);

  localparam int CW = clog2_min1(NUM_CELLS);
  localparam logic [CW-1:0] LAST_CELL = CW'(NUM_CELLS - 1);

  if (!tw_fits_words(TW, WORD_W)) begin : g_tw_check
    $error("table width must be a multiple of the config word width");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cell_cnt;
  logic [GEN_W-1:0] gens_q;
  logic             last_beat;
  logic             run_last;

  ca_table_assembler #(
    .TW     (TW),
    .WORD_W (WORD_W)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .accept      (cfg_valid && cfg_ready),
    .data        (cfg_data),
    .chain_table (chain_table),
    .last_beat   (last_beat)
  );

  assign run_last = ((gen_count + GEN_W'(1)) == gens_q);

  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    chain_init = 1'b0;
    step_en    = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid && last_beat) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        chain_init = 1'b1;
        state_nxt  = (cell_cnt == LAST_CELL) ? ST_CONFIGURED : ST_LOAD;
      end
      ST_CONFIGURED: begin
        // reconfig outranks start when both arrive together
        if (reconfig) state_nxt = ST_LOAD;
        else if (start && (num_gens != '0)) state_nxt = ST_RUN_STEP;
      end
      ST_RUN_STEP: begin
        step_en   = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_RUN_WAIT;
      end
      ST_RUN_WAIT: begin
        busy = 1'b1;
        if (step_done) state_nxt = run_last ? ST_CONFIGURED : ST_RUN_STEP;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      cell_cnt   <= '0;
      configured <= 1'b0;
      gen_count  <= '0;
      gens_q     <= '0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        ST_INIT: begin
          cell_cnt <= cell_cnt + 1'b1;
          if (cell_cnt == LAST_CELL) configured <= 1'b1;
        end
        ST_CONFIGURED: begin
          if (reconfig) begin
            configured <= 1'b0;
            cell_cnt   <= '0;
          end else if (start) begin
            gens_q    <= num_gens;
            gen_count <= '0;
            done      <= (num_gens == '0);
          end
        end
        ST_RUN_WAIT: begin
          if (step_done) begin
            gen_count <= gen_count + 1'b1;
            done      <= run_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
